// File: rtl/morse_key_decoder.sv
// Morse push-button decoder: synchronise/debounce the key, time presses and gaps in
// Morse units, collect up to four dot/dash elements and decode them to a letter code.
module morse_key_decoder #(
  parameter int unsigned CLK_PER_UNIT = 5_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned DASH_UNITS   = 2,
  parameter int unsigned GAP_UNITS    = 3
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       key,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic [2:0] symbol_len,
  output logic       err
);

  localparam int unsigned UNIT_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(CLK_PER_UNIT - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]        DASH_U    = 3'(DASH_UNITS);
  localparam logic [2:0]        GAP_U     = 3'(GAP_UNITS);
  localparam logic [2:0]        UNITS_MAX = 3'd7;
  localparam logic [2:0]        LEN_MAX   = 3'd4;
  localparam logic [4:0]        BLANK     = 5'd31;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRESS  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DECODE = 2'd3;

  logic              key_meta;
  logic              key_s;
  logic              key_db;
  logic              key_db_q;
  logic [DB_W-1:0]   db_cnt;
  logic [UNIT_W-1:0] unit_cnt;
  logic [2:0]        units;
  logic [2:0]        units_n;
  logic [2:0]        units_inc;
  logic [3:0]        code;
  logic [3:0]        code_n;
  logic [2:0]        len;
  logic [2:0]        len_n;
  logic              ovf;
  logic              ovf_n;
  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [4:0]        letter_n;
  logic              err_n;
  logic              valid_n;
  logic [4:0]        dec_letter;
  logic              key_rise;
  logic              key_fall;
  logic              tick;
  logic              gap_done;

  // Standard Morse table; code bit i is element i (1 = dash), unused bits are zero.
  function automatic logic [4:0] morse_lookup(input logic [3:0] c, input logic [2:0] n);
    logic [4:0] r;
    r = BLANK;
    case (n)
      3'd1: r = c[0] ? 5'd19 : 5'd4;
      3'd2: begin
        case (c[1:0])
          2'd0:    r = 5'd8;
          2'd1:    r = 5'd13;
          2'd2:    r = 5'd0;
          default: r = 5'd12;
        endcase
      end
      3'd3: begin
        case (c[2:0])
          3'd0:    r = 5'd18;
          3'd1:    r = 5'd3;
          3'd2:    r = 5'd17;
          3'd3:    r = 5'd6;
          3'd4:    r = 5'd20;
          3'd5:    r = 5'd10;
          3'd6:    r = 5'd22;
          default: r = 5'd14;
        endcase
      end
      3'd4: begin
        case (c)
          4'd0:    r = 5'd7;
          4'd1:    r = 5'd1;
          4'd2:    r = 5'd11;
          4'd3:    r = 5'd25;
          4'd4:    r = 5'd5;
          4'd5:    r = 5'd2;
          4'd6:    r = 5'd15;
          4'd8:    r = 5'd21;
          4'd9:    r = 5'd23;
          4'd11:   r = 5'd16;
          4'd13:   r = 5'd24;
          4'd14:   r = 5'd9;
          default: r = BLANK;
        endcase
      end
      default: r = BLANK;
    endcase
    return r;
  endfunction

  // Two-flop synchroniser for the asynchronous key.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key;
      key_s    <= key_meta;
    end
  end

  // Debounce: follow key_s only after it has disagreed for DEBOUNCE_CYC straight cycles.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      key_db   <= 1'b0;
      key_db_q <= 1'b0;
    end else begin
      key_db_q <= key_db;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign key_rise = key_db & ~key_db_q;
  assign key_fall = ~key_db & key_db_q;
  assign tick     = (unit_cnt == UNIT_LAST);

  // Unit timer restarts on every debounced edge so durations are measured from the edge.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      unit_cnt <= '0;
    end else if (key_rise || key_fall || tick) begin
      unit_cnt <= '0;
    end else begin
      unit_cnt <= unit_cnt + UNIT_W'(1);
    end
  end

  assign units_inc  = (units == UNITS_MAX) ? units : units + 3'd1;
  assign gap_done   = tick && (units_inc == GAP_U);
  assign dec_letter = morse_lookup(code, len);
  assign symbol_len = (state == S_IDLE) ? 3'd0 : len;

  // Next-state and datapath updates; the gap winning over a simultaneous rise is deliberate.
  always_comb begin
    state_n  = state;
    code_n   = code;
    len_n    = len;
    ovf_n    = ovf;
    letter_n = letter;
    err_n    = err;
    valid_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_rise) state_n = S_PRESS;
      end
      S_PRESS: begin
        if (key_fall) begin
          if (len < LEN_MAX) begin
            code_n[len[1:0]] = (units >= DASH_U);
            len_n            = len + 3'd1;
          end else begin
            ovf_n = 1'b1;
          end
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          state_n = S_DECODE;
          valid_n = 1'b1;
          if (ovf) begin
            letter_n = BLANK;
            err_n    = 1'b1;
          end else begin
            letter_n = dec_letter;
            err_n    = (dec_letter == BLANK);
          end
        end else if (key_rise) begin
          state_n = S_PRESS;
        end
      end
      S_DECODE: begin
        code_n  = 4'd0;
        len_n   = 3'd0;
        ovf_n   = 1'b0;
        state_n = key_db ? S_PRESS : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    units_n = tick ? units_inc : units;
    if (state_n != state) units_n = 3'd0;
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      units        <= 3'd0;
      code         <= 4'd0;
      len          <= 3'd0;
      ovf          <= 1'b0;
      letter       <= BLANK;
      err          <= 1'b0;
      letter_valid <= 1'b0;
    end else begin
      state        <= state_n;
      units        <= units_n;
      code         <= code_n;
      len          <= len_n;
      ovf          <= ovf_n;
      letter       <= letter_n;
      err          <= err_n;
      letter_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: a string-level Morse model predicts every decoded letter,
// a per-cycle monitor checks pulses and held outputs, directed checks pin literal values.
module tb_morse_key_decoder;

  localparam int unsigned CPU  = 10;
  localparam int unsigned DBC  = 4;
  localparam int unsigned DASH = 2;
  localparam int unsigned GAPU = 3;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       key       = 1'b0;
  logic [4:0] letter;
  logic       letter_valid;
  logic [2:0] symbol_len;
  logic       err;

  int checks = 0;
  int errors = 0;

  string morse_tab [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string elems = "";
  int    exp_q[$];
  int    held_letter = 31;
  int    held_err    = 0;

  morse_key_decoder #(
    .CLK_PER_UNIT(CPU),
    .DEBOUNCE_CYC(DBC),
    .DASH_UNITS  (DASH),
    .GAP_UNITS   (GAPU)
  ) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .key         (key),
    .letter      (letter),
    .letter_valid(letter_valid),
    .symbol_len  (symbol_len),
    .err         (err)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  // Model: look the collected element string up in the table; anything else is blank + err.
  function automatic void close_letter();
    int idx;
    idx = 31;
    if (elems.len() <= 4)
      for (int i = 0; i < 26; i++)
        if (elems == morse_tab[i]) idx = i;
    exp_q.push_back(idx);
    elems = "";
  endfunction

  task automatic raw(input logic v, input int n);
    key = v;
    step(n);
  endtask

  task automatic press(input int n);
    key = 1'b1;
    step(n);
    if (n >= int'(DASH * CPU)) elems = {elems, "-"};
    else                       elems = {elems, "."};
  endtask

  task automatic gap(input int n);
    key = 1'b0;
    if (n >= int'(GAPU * CPU)) close_letter();
    step(n);
  endtask

  task automatic gap_chk(input int n, input int exp_len);
    key = 1'b0;
    if (n >= int'(GAPU * CPU)) close_letter();
    step(12);
    chk("symbol_len", int'(symbol_len), exp_len);
    step(n - 12);
  endtask

  task automatic expect_out(input string name, input int l, input int e);
    chk({name, "_letter"}, int'(letter), l);
    chk({name, "_err"}, int'(err), e);
  endtask

  // Per-cycle monitor: reset values, one pulse per predicted letter, outputs held otherwise.
  always @(negedge board_clk) begin
    if (reset) begin
      chk("rst_letter", int'(letter), 31);
      chk("rst_err", int'(err), 0);
      chk("rst_valid", int'(letter_valid), 0);
      chk("rst_symbol_len", int'(symbol_len), 0);
    end else if (letter_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        held_letter = exp_q.pop_front();
        held_err    = (held_letter == 31) ? 1 : 0;
        chk("decoded_letter", int'(letter), held_letter);
        chk("decoded_err", int'(err), held_err);
      end
    end else begin
      chk("held_letter", int'(letter), held_letter);
      chk("held_err", int'(err), held_err);
    end
    checks++;
    if (symbol_len > 3'd4) begin
      errors++;
      $display("FAIL symbol_len_range actual=%0d required<=4", symbol_len);
    end
  end

  initial begin
    step(3);
    reset = 1'b0;
    step(5);

    // Single dot: E
    press(15);
    gap(60);
    expect_out("E", 4, 0);

    // -.-. : C, element count steps through each gap
    press(35); gap_chk(15, 1);
    press(15); gap_chk(15, 2);
    press(35); gap_chk(15, 3);
    press(15); gap_chk(60, 4);
    expect_out("C", 2, 0);

    // ---- is not a letter
    for (int i = 0; i < 3; i++) begin
      press(35);
      gap(15);
    end
    press(35);
    gap(60);
    expect_out("dash4", 31, 1);
    press(15);
    gap(60);
    expect_out("E_after_err", 4, 0);

    // Five elements overflow
    for (int i = 0; i < 4; i++) begin
      press(15);
      gap(15);
    end
    press(15);
    gap_chk(60, 4);
    expect_out("ovf", 31, 1);

    // Reset mid-press with the key held through reset
    raw(1'b1, 10);
    reset = 1'b1;
    exp_q.delete();
    elems       = "";
    held_letter = 31;
    held_err    = 0;
    step(2);
    expect_out("in_reset", 31, 0);
    chk("in_reset_symbol_len", int'(symbol_len), 0);
    reset = 1'b0;
    press(15);
    gap(60);
    expect_out("E_after_reset", 4, 0);

    // Glitches are ignored, bounces around a real press collapse to one E
    for (int g = 1; g <= 3; g++) begin
      raw(1'b1, g);
      raw(1'b0, 8);
    end
    chk("glitch_symbol_len", int'(symbol_len), 0);
    raw(1'b1, 1); raw(1'b0, 1); raw(1'b1, 2); raw(1'b0, 1);
    press(15);
    raw(1'b0, 1); raw(1'b1, 1);
    gap(60);
    expect_out("E_bounce", 4, 0);

    chk("pending_letters", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
